// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the external 1Mx16 asynchronous SRAM controller.
//   state_e  : controller phase (idle, low half, turnaround, high half, done)
//   SRAM_AW  : SRAM half-word address width
//   SRAM_DW  : SRAM data width
//   WIN_BITS : log2 of the 2 MB bus window decoded by the controller
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW  = 20;
  localparam int unsigned SRAM_DW  = 16;
  localparam int unsigned WIN_BITS = 21;

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StTurn,
    StHi,
    StDone
  } state_e;

endpackage

// File: rtl/sram_dq_buf.sv
// Registered 16-bit tri-state pad for the SRAM data bus.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   oe_i, dout_i  : drive enable and drive data, registered before reaching the pad
//   cap_i         : capture strobe; the pad value is registered into cap_o
//   din_o         : raw pad value (feeds the controller's read-data register)
//   cap_o         : captured half-word
//   dq_io         : SRAM data pins
module sram_dq_buf
  import sram_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               oe_i,
  input  logic [SRAM_DW-1:0] dout_i,
  input  logic               cap_i,
  output logic [SRAM_DW-1:0] din_o,
  output logic [SRAM_DW-1:0] cap_o,
  inout  wire  [SRAM_DW-1:0] dq_io
);

  logic               oe_q;
  logic [SRAM_DW-1:0] dout_q;
  logic [SRAM_DW-1:0] cap_q;

  // Enable resets asynchronously so the bus is released as soon as reset asserts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
      cap_q  <= '0;
    end else begin
      oe_q   <= oe_i;
      dout_q <= dout_i;
      if (cap_i) cap_q <= dq_io;
    end
  end

  assign dq_io = oe_q ? dout_q : {SRAM_DW{1'bz}};
  assign din_o = dq_io;
  assign cap_o = cap_q;

endmodule

// File: rtl/sram_ctrl.sv
// Bus slave mapping a 1Mx16 asynchronous SRAM into a 2 MB window of the CPU address space.
// Each 32-bit access becomes two 16-bit SRAM cycles (low half, turnaround, high half) followed
// by a one-cycle READY pulse. All outputs are registered.
//   ACLK, ARESETN        : clock, asynchronous active-low reset
//   ADDR, DATA_I, DATA_O : CPU byte address, write data, read data (zero outside read completion)
//   WRSTB, RDSTB         : level request strobes held until READY; write wins if both are set
//   READY, BUSY          : completion pulse, access in progress
//   SRAM_*               : SRAM address, data and active-low controls
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [31:0]        ADDR,
  input  logic [31:0]        DATA_I,
  output logic [31:0]        DATA_O,
  input  logic               WRSTB,
  input  logic               RDSTB,
  output logic               READY,
  output logic               BUSY,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N
);

  localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES);
  localparam int unsigned WordAw  = WIN_BITS - 2;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [WordAw-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                hit, accept, phase_end, seg_on, xfer_on, cap_en;
  logic                ce_n_q, oe_n_q, we_n_q, ready_q, busy_q;
  logic                ce_n_d, oe_n_d, we_n_d, ready_d, busy_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic [31:0]         data_o_q, data_o_d;
  logic                dq_oe_d;
  logic [SRAM_DW-1:0]  dq_dout_d, dq_din, dq_cap;
  logic                unused_addr;

  assign unused_addr = ^ADDR[1:0];
  assign hit         = ADDR[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS];
  assign phase_end   = cnt_q == WaitLast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit && (WRSTB || RDSTB)) begin
          state_d = StLo;
          cnt_d   = '0;
          accept  = 1'b1;
        end
      end
      StLo: begin
        if (phase_end) begin
          state_d = StTurn;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StTurn: state_d = StHi;
      StHi: begin
        if (phase_end) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so pins line up with the phase they belong to.
  assign wr_d    = accept ? WRSTB : wr_q;
  assign waddr_d = accept ? ADDR[WIN_BITS-1:2] : waddr_q;
  assign wdata_d = accept ? DATA_I : wdata_q;
  assign seg_on  = state_d inside {StLo, StTurn, StHi};
  assign xfer_on = state_d inside {StLo, StHi};
  // Low half is latched at the end of LO; the high half is taken straight off the pad into DATA_O.
  assign cap_en  = (state_q == StLo) && phase_end && !wr_q;

  always_comb begin
    ce_n_d      = !seg_on;
    oe_n_d      = !(xfer_on && !wr_d);
    we_n_d      = !(xfer_on && wr_d);
    dq_oe_d     = xfer_on && wr_d;
    dq_dout_d   = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
    ready_d     = state_d == StDone;
    busy_d      = state_d != StIdle;
    data_o_d    = (state_d == StDone && !wr_d) ? {dq_din, dq_cap} : '0;
    // Address is held after the access so it never moves under an active chip enable.
    sram_addr_d = sram_addr_q;
    if (state_d == StLo) begin
      sram_addr_d = {waddr_d, 1'b0};
    end else if (state_d inside {StTurn, StHi}) begin
      sram_addr_d = {waddr_d, 1'b1};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      data_o_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      sram_addr_q <= sram_addr_d;
      data_o_q    <= data_o_d;
    end
  end

  sram_dq_buf u_dq_buf (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .oe_i   (dq_oe_d),
    .dout_i (dq_dout_d),
    .cap_i  (cap_en),
    .din_o  (dq_din),
    .cap_o  (dq_cap),
    .dq_io  (SRAM_DQ)
  );

  assign SRAM_CE_N = ce_n_q;
  assign SRAM_LB_N = ce_n_q;
  assign SRAM_UB_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_ADDR = sram_addr_q;
  assign READY     = ready_q;
  assign BUSY      = busy_q;
  assign DATA_O    = data_o_q;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  localparam int W   = 1;
  localparam int LAT = 2 * (W + 1) + 2;
  localparam logic [31:0] BASE = 32'h0020_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] DATA_I = '0;
  logic        WRSTB = 1'b0;
  logic        RDSTB = 1'b0;
  logic [31:0] DATA_O;
  logic        READY, BUSY;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

  int n_checks = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  sram_ctrl #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .ADDR      (ADDR),
    .DATA_I    (DATA_I),
    .DATA_O    (DATA_O),
    .WRSTB     (WRSTB),
    .RDSTB     (RDSTB),
    .READY     (READY),
    .BUSY      (BUSY),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_UB_N (SRAM_UB_N)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endfunction

  // Asynchronous SRAM: drives DQ on a read, commits a half when WE_N returns high.
  bit   [15:0] sram_mem [0:1048575];
  logic        sram_rd;
  logic [19:0] pend_a;
  logic [15:0] pend_d;
  bit          pend_v = 1'b0;

  assign sram_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = sram_rd ? sram_mem[SRAM_ADDR] : 16'hzzzz;

  always @(negedge ACLK) begin
    if (!SRAM_WE_N) begin
      pend_a = SRAM_ADDR;
      pend_d = SRAM_DQ;
      pend_v = 1'b1;
    end else if (pend_v) begin
      sram_mem[pend_a] = pend_d;
      pend_v = 1'b0;
    end
  end

  // Transaction-level model: m_k counts cycles since the accepting edge.
  bit          m_active = 1'b0;
  bit          m_wr = 1'b0;
  int          m_k = 0;
  logic [18:0] m_a = '0;
  logic [31:0] m_d = '0;
  logic [19:0] m_sa = '0;
  bit   [31:0] word_mem [int unsigned];

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_active = 1'b0;
      m_k      = 0;
      m_sa     = '0;
    end else if (m_active) begin
      m_k++;
      if (m_k > LAT) begin
        m_active = 1'b0;
        m_k      = 0;
      end else if (m_k == LAT && m_wr) begin
        word_mem[int'(m_a)] = m_d;
      end
    end else if (ADDR >= BASE && ADDR < BASE + 32'h0020_0000 && (WRSTB || RDSTB)) begin
      m_active = 1'b1;
      m_k      = 1;
      m_wr     = WRSTB;
      m_a      = ADDR[20:2];
      m_d      = DATA_I;
    end
    if (m_active && m_k <= 2 * W + 3) m_sa = {m_a, (m_k > W + 1)};
  end

  always @(negedge ACLK) begin
    bit          lo, turn, hi, done;
    logic [31:0] exp_data;
    lo   = m_active && m_k >= 1 && m_k <= W + 1;
    turn = m_active && m_k == W + 2;
    hi   = m_active && m_k >= W + 3 && m_k <= 2 * W + 3;
    done = m_active && m_k == LAT;
    chk1("ce_n", SRAM_CE_N, !(lo || turn || hi));
    chk1("lb_n", SRAM_LB_N, !(lo || turn || hi));
    chk1("ub_n", SRAM_UB_N, !(lo || turn || hi));
    chk1("oe_n", SRAM_OE_N, !(!m_wr && (lo || hi)));
    chk1("we_n", SRAM_WE_N, !(m_wr && (lo || hi)));
    chk("sram_addr", {12'd0, SRAM_ADDR}, {12'd0, m_sa});
    chk1("ready", READY, done);
    chk1("busy", BUSY, m_active);
    exp_data = '0;
    if (done && !m_wr && word_mem.exists(int'(m_a))) exp_data = word_mem[int'(m_a)];
    chk("data_o", DATA_O, exp_data);
    if (m_wr && (lo || hi)) begin
      chk("dq_drive", {16'd0, SRAM_DQ}, {16'd0, hi ? m_d[31:16] : m_d[15:0]});
    end else if (SRAM_OE_N) begin
      n_checks++;
      if (SRAM_DQ !== 16'hzzzz) begin
        n_err++;
        $display("FAIL dq_hiz: got %h, expected zzzz at %0t", SRAM_DQ, $time);
      end
    end
  end

  // Per-access trace, indexed by negedge number after the strobe is raised.
  logic [19:0] tr_addr [0:47];
  logic        tr_we   [0:47];
  logic [15:0] tr_dq   [0:47];
  logic [31:0] tr_data [0:47];
  int          n_we, n_oe;

  // Called at a negedge; raises the strobes immediately and drops them once READY is seen.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit rd,
                        output int lat, output logic [31:0] rdata);
    ADDR = a;
    DATA_I = d;
    WRSTB = wr;
    RDSTB = rd;
    lat = 0;
    rdata = '0;
    n_we = 0;
    n_oe = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge ACLK);
      tr_addr[i] = SRAM_ADDR;
      tr_we[i]   = SRAM_WE_N;
      tr_dq[i]   = SRAM_DQ;
      tr_data[i] = DATA_O;
      if (!SRAM_WE_N) n_we++;
      if (!SRAM_OE_N) n_oe++;
      if (READY) begin
        lat = i;
        rdata = DATA_O;
        break;
      end
    end
    WRSTB = 1'b0;
    RDSTB = 1'b0;
    chk1("ready_seen", lat != 0, 1'b1);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    int          n_rdy, n_bsy, n_ctl;

    repeat (3) @(negedge ACLK);
    chk1("rst_ce_n", SRAM_CE_N, 1'b1);
    chk1("rst_we_n", SRAM_WE_N, 1'b1);
    chk1("rst_busy", BUSY, 1'b0);
    chk("rst_addr", {12'd0, SRAM_ADDR}, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Write 0xDEADBEEF to 0x0020_0010.
    access(32'h0020_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, lat, rd);
    chk("wr_latency", lat, 6);
    chk("wr_lo_addr", {12'd0, tr_addr[1]}, 32'h0000_0008);
    chk("wr_lo_dq", {16'd0, tr_dq[2]}, 32'h0000_BEEF);
    chk1("wr_lo_we", tr_we[2], 1'b0);
    chk1("wr_turn_we", tr_we[3], 1'b1);
    chk("wr_hi_addr", {12'd0, tr_addr[4]}, 32'h0000_0009);
    chk("wr_hi_dq", {16'd0, tr_dq[5]}, 32'h0000_DEAD);
    chk("wr_we_cycles", n_we, 4);
    @(negedge ACLK);
    chk("sram_lo_half", {16'd0, sram_mem[20'h00008]}, 32'h0000_BEEF);
    chk("sram_hi_half", {16'd0, sram_mem[20'h00009]}, 32'h0000_DEAD);

    // Read it back.
    access(32'h0020_0010, 32'h0, 1'b0, 1'b1, lat, rd);
    chk("rd_latency", lat, 6);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_data_before", tr_data[5], 32'h0);
    chk("rd_oe_cycles", n_oe, 4);
    chk("rd_we_cycles", n_we, 0);
    @(negedge ACLK);
    chk("rd_data_after", DATA_O, 32'h0);

    // Back-to-back: second strobe raised in the DONE cycle, accepted in the first IDLE cycle.
    access(32'h0020_0014, 32'hCAFE_F00D, 1'b1, 1'b0, lat, rd);
    access(32'h0020_0014, 32'h0, 1'b0, 1'b1, lat, rd);
    chk("b2b_latency", lat, LAT + 1);
    chk("b2b_data", rd, 32'hCAFE_F00D);
    @(negedge ACLK);

    // Top word of the window.
    access(32'h003F_FFFC, 32'h0BAD_F00D, 1'b1, 1'b0, lat, rd);
    chk("top_lo_addr", {12'd0, tr_addr[1]}, 32'h000F_FFFE);
    chk("top_hi_addr", {12'd0, tr_addr[4]}, 32'h000F_FFFF);
    @(negedge ACLK);
    access(32'h003F_FFFC, 32'h0, 1'b0, 1'b1, lat, rd);
    chk("top_rd_data", rd, 32'h0BAD_F00D);
    @(negedge ACLK);

    // Both strobes: write wins.
    access(32'h0020_0018, 32'h55AA_33CC, 1'b1, 1'b1, lat, rd);
    chk("both_we_cycles", n_we, 4);
    chk("both_oe_cycles", n_oe, 0);
    @(negedge ACLK);
    access(32'h0020_0018, 32'h0, 1'b0, 1'b1, lat, rd);
    chk("both_rd_data", rd, 32'h55AA_33CC);
    @(negedge ACLK);

    // Miss: nothing happens for 20 cycles.
    ADDR = 32'h0010_0000;
    RDSTB = 1'b1;
    WRSTB = 1'b0;
    n_rdy = 0;
    n_bsy = 0;
    n_ctl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (READY) n_rdy++;
      if (BUSY) n_bsy++;
      if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || !SRAM_LB_N || !SRAM_UB_N) n_ctl++;
    end
    RDSTB = 1'b0;
    chk("miss_ready", n_rdy, 0);
    chk("miss_busy", n_bsy, 0);
    chk("miss_ctl", n_ctl, 0);

    // Reset during the high half of a write.
    ADDR = 32'h0020_0020;
    DATA_I = 32'h1234_5678;
    WRSTB = 1'b1;
    repeat (W + 3) @(negedge ACLK);
    chk1("abort_hi_we", SRAM_WE_N, 1'b0);
    chk("abort_hi_addr", {12'd0, SRAM_ADDR}, 32'h0000_0011);
    #1;
    ARESETN = 1'b0;
    WRSTB = 1'b0;
    #1;
    chk1("abort_ce_n", SRAM_CE_N, 1'b1);
    chk1("abort_oe_n", SRAM_OE_N, 1'b1);
    chk1("abort_we_n", SRAM_WE_N, 1'b1);
    chk1("abort_lb_n", SRAM_LB_N, 1'b1);
    chk1("abort_ub_n", SRAM_UB_N, 1'b1);
    chk1("abort_ready", READY, 1'b0);
    n_checks++;
    if (SRAM_DQ !== 16'hzzzz) begin
      n_err++;
      $display("FAIL abort_dq: got %h, expected zzzz", SRAM_DQ);
    end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    access(32'h0020_0010, 32'h0, 1'b0, 1'b1, lat, rd);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_data", rd, 32'hDEAD_BEEF);
    repeat (3) @(negedge ACLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
